// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access-size encodings, data-memory FSM states and the
// load lane-select/extend helper used by any unit returning load data.
package cpu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Picks the addressed lane(s) out of a little-endian word and extends to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  res = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_H:  res = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            SIZE_W:  res = word;
            default: res = 32'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM, 2^ADDR_WIDTH x 32, byte-enable writes and registered read.
// Contents have no reset; the read register only updates when re_i is set.
module dmem_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, wait states, byte/half/word access
// on dmem_ram, extended load data or error out.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [31:0]           wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;

    logic                  req_illegal;
    logic                  access_en;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    always_comb begin
        req_illegal = 1'b0;
        case (req_size_i)
            SIZE_B:  req_illegal = 1'b0;
            SIZE_H:  req_illegal = req_addr_i[0];
            SIZE_W:  req_illegal = (req_addr_i[1:0] != 2'b00);
            default: req_illegal = 1'b1;
        endcase
        if ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0) begin
            req_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            size_q      <= SIZE_B;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_i[ADDR_WIDTH+1:0];
                        size_q     <= req_size_i;
                        write_q    <= req_write_i;
                        unsigned_q <= req_unsigned_i;
                        wdata_q    <= req_wdata_i;
                        if (req_illegal) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The RAM access happens on the last BUSY edge; reset forces IDLE so aborted stores drop.
    assign access_en = (state_q == StBusy) && (cnt_q == 4'd0);

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = wdata_q;
        case (size_q)
            SIZE_B: begin
                ram_be    = 4'b0001 << addr_q[1:0];
                ram_wdata = {4{wdata_q[7:0]}};
            end
            SIZE_H: begin
                ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = wdata_q;
            end
        endcase
    end

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (access_en & write_q),
        .be_i   (ram_be),
        .re_i   (access_en & ~write_q),
        .addr_i (addr_q[ADDR_WIDTH+1:2]),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign req_ready_o = (state_q == StIdle) & ~rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    // Built only from registers, so rdata holds steady in RESP and reads 0 elsewhere.
    assign rsp_rdata_o = (state_q == StResp && !rsp_err_q && !write_q)
                       ? load_extend(ram_rdata, addr_q[1:0], size_q, unsigned_q) : 32'd0;

endmodule
